// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore sequencer for a shared-memory multi-cycle core.
// Controls are registered from the next state; only the fetch strobes see mem_ready.
module multicycle_control_unit #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_ext,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_ext;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  state_t             r_state;
  state_t             w_next;
  ctrl_t              r_ctl;
  ctrl_t              w_ctl;
  logic [5:0]         r_opcode;
  logic [5:0]         r_funct;
  logic [COUNT_W-1:0] r_count;
  logic [5:0]         w_op;
  logic [5:0]         w_fn;
  logic [2:0]         w_r_alu;
  logic               w_r_ok;
  logic               w_fetch_done;
  logic               w_retire;

  // IR fields are live in DECODE and frozen copies afterwards
  assign w_op = (r_state == S_DECODE) ? opcode : r_opcode;
  assign w_fn = (r_state == S_DECODE) ? funct : r_funct;

  // r_ctl.fetch stays low until the first edge after clear
  assign w_fetch_done = r_ctl.fetch & mem_ready;
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

  always_comb begin
    w_r_ok  = 1'b1;
    w_r_alu = ALU_AND;
    case (w_fn)
      6'h20:   w_r_alu = ALU_ADD;
      6'h22:   w_r_alu = ALU_SUB;
      6'h24:   w_r_alu = ALU_AND;
      6'h25:   w_r_alu = ALU_OR;
      6'h2A:   w_r_alu = ALU_SLT;
      default: w_r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:
        if (w_fetch_done) w_next = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_RTYPE:        w_next = S_R_EXEC;
          OP_BEQ:          w_next = S_BRANCH;
          OP_ADDI, OP_ORI: w_next = S_IMM_EXEC;
          OP_J:            w_next = S_JUMP;
          default:         w_next = S_HALT;
        endcase
      S_MEM_ADDR:
        w_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:
        if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE:
        if (mem_ready) w_next = S_FETCH;
      S_R_EXEC:
        w_next = w_r_ok ? S_R_WB : S_HALT;
      S_IMM_EXEC:
        w_next = S_IMM_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_IMM_WB, S_JUMP:
        w_next = S_FETCH;
      default:
        w_next = S_HALT;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    case (w_next)
      S_FETCH: begin
        w_ctl.fetch     = 1'b1;
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = 2'd1;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        w_ctl.alu_src_b = 2'd3;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = 2'd2;
        w_ctl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
      end
      S_R_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_op    = w_r_alu;
      end
      S_R_WB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_op        = ALU_SUB;
        w_ctl.pc_write_cond = 1'b1;
        w_ctl.pc_source     = 2'd1;
      end
      S_IMM_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = 2'd2;
        w_ctl.imm_ext   = (w_op == OP_ORI);
        w_ctl.alu_op    = (w_op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMM_WB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.imm_ext   = (w_op == OP_ORI);
        w_ctl.alu_op    = (w_op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_JUMP: begin
        w_ctl.pc_write  = 1'b1;
        w_ctl.pc_source = 2'd2;
      end
      S_HALT:
        w_ctl.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state  <= S_FETCH;
      r_ctl    <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= w_ctl;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        r_funct  <= funct;
      end
      if (w_retire) r_count <= r_count + COUNT_W'(1);
    end
  end

  assign pc_write      = r_ctl.pc_write | w_fetch_done;
  assign pc_write_cond = r_ctl.pc_write_cond;
  assign i_or_d        = r_ctl.i_or_d;
  assign mem_read      = r_ctl.mem_read;
  assign mem_write     = r_ctl.mem_write;
  assign ir_write      = w_fetch_done;
  assign reg_dst       = r_ctl.reg_dst;
  assign reg_write     = r_ctl.reg_write;
  assign mem_to_reg    = r_ctl.mem_to_reg;
  assign alu_src_a     = r_ctl.alu_src_a;
  assign alu_src_b     = r_ctl.alu_src_b;
  assign imm_ext       = r_ctl.imm_ext;
  assign alu_op        = r_ctl.alu_op;
  assign pc_source     = r_ctl.pc_source;
  assign state         = r_state;
  assign halted        = r_ctl.halted;
  assign instr_count   = r_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction sequences with
// hand-computed state walks and control values.
module tb_multicycle_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d;
  logic        mem_read, mem_write, ir_write;
  logic        reg_dst, reg_write, mem_to_reg;
  logic        alu_src_a, imm_ext, halted;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0;
  int n_ir  = 0;

  logic [5:0] fn_tab [4];
  logic [2:0] op_tab [4];

  always #5 clock = ~clock;

  multicycle_control_unit #(.COUNT_W(32)) dut (
    .clock(clock), .clear(clear),
    .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .imm_ext(imm_ext),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .state(state),
    .halted(halted),
    .instr_count(instr_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one clock: sample the settled cycle, then land on the next negedge
  task automatic tick();
    #1;
    if (ir_write) n_ir++;
    n_cyc++;
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    fn_tab[0] = 6'h22; op_tab[0] = 3'b110;
    fn_tab[1] = 6'h24; op_tab[1] = 3'b000;
    fn_tab[2] = 6'h25; op_tab[2] = 3'b001;
    fn_tab[3] = 6'h2A; op_tab[3] = 3'b111;

    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_alu_b", 32'(alu_src_b), 0);
    chk("rst_cnt", instr_count, 0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("fetch_state", 32'(state), 0);
    chk("fetch_mem_read", 32'(mem_read), 1);
    chk("fetch_alu_b", 32'(alu_src_b), 1);
    chk("fetch_alu_op", 32'(alu_op), 2);
    chk("fetch_ir_idle", 32'(ir_write), 0);

    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    #1;
    chk("add_ir", 32'(ir_write), 1);
    chk("add_pcw", 32'(pc_write), 1);
    tick();
    mem_ready = 1'b0;
    chk("add_dec_state", 32'(state), 1);
    chk("add_dec_alub", 32'(alu_src_b), 3);
    chk("add_dec_ir", 32'(ir_write), 0);
    tick();
    chk("add_ex_state", 32'(state), 6);
    chk("add_ex_aluop", 32'(alu_op), 2);
    chk("add_ex_srca", 32'(alu_src_a), 1);
    chk("add_ex_srcb", 32'(alu_src_b), 0);
    tick();
    chk("add_wb_state", 32'(state), 7);
    chk("add_wb_dst", 32'(reg_dst), 1);
    chk("add_wb_we", 32'(reg_write), 1);
    chk("add_wb_cnt", instr_count, 0);
    tick();
    chk("add_done_state", 32'(state), 0);
    chk("add_done_cnt", instr_count, 1);

    for (int i = 0; i < 4; i++) begin
      fetch(6'h00, fn_tab[i]);
      tick();
      chk("rtype_aluop", 32'(alu_op), 32'(op_tab[i]));
      tick();
      tick();
    end
    chk("rtype_cnt", instr_count, 5);

    n_cyc = 0; n_ir = 0;
    opcode = 6'h23; mem_ready = 1'b0;
    repeat (3) tick();
    chk("lw_fetch_wait", 32'(state), 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lw_dec", 32'(state), 1);
    tick();
    chk("lw_addr", 32'(state), 2);
    chk("lw_addr_srcb", 32'(alu_src_b), 2);
    chk("lw_addr_ext", 32'(imm_ext), 0);
    tick();
    chk("lw_rd", 32'(state), 3);
    chk("lw_rd_iord", 32'(i_or_d), 1);
    chk("lw_rd_mr", 32'(mem_read), 1);
    tick();
    tick();
    chk("lw_rd_hold", 32'(state), 3);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lw_wb", 32'(state), 4);
    chk("lw_wb_m2r", 32'(mem_to_reg), 1);
    chk("lw_wb_we", 32'(reg_write), 1);
    chk("lw_wb_dst", 32'(reg_dst), 0);
    tick();
    chk("lw_done", 32'(state), 0);
    chk("lw_cycles", n_cyc, 10);
    chk("lw_ir_pulses", n_ir, 1);
    chk("lw_cnt", instr_count, 6);

    fetch(6'h2B, 6'h00);
    tick();
    tick();
    chk("sw_state", 32'(state), 5);
    chk("sw_mw", 32'(mem_write), 1);
    chk("sw_iord", 32'(i_or_d), 1);
    tick();
    chk("sw_hold", 32'(state), 5);
    chk("sw_hold_cnt", instr_count, 6);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("sw_done", 32'(state), 0);
    chk("sw_cnt", instr_count, 7);

    fetch(6'h0D, 6'h00);
    tick();
    chk("ori_ex", 32'(state), 9);
    chk("ori_ex_ext", 32'(imm_ext), 1);
    chk("ori_ex_op", 32'(alu_op), 1);
    chk("ori_ex_srcb", 32'(alu_src_b), 2);
    opcode = 6'h08;
    tick();
    chk("ori_wb", 32'(state), 10);
    chk("ori_wb_ext", 32'(imm_ext), 1);
    chk("ori_wb_op", 32'(alu_op), 1);
    chk("ori_wb_we", 32'(reg_write), 1);
    tick();
    chk("ori_cnt", instr_count, 8);

    fetch(6'h08, 6'h00);
    tick();
    chk("addi_ex_ext", 32'(imm_ext), 0);
    chk("addi_ex_op", 32'(alu_op), 2);
    tick();
    chk("addi_wb_op", 32'(alu_op), 2);
    chk("addi_wb_we", 32'(reg_write), 1);
    tick();

    fetch(6'h23, 6'h00);
    tick();
    tick();
    chk("clr_pre", 32'(state), 3);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_state", 32'(state), 0);
    chk("clr_mr", 32'(mem_read), 0);
    chk("clr_iord", 32'(i_or_d), 0);
    chk("clr_cnt", instr_count, 0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    fetch(6'h04, 6'h00);
    tick();
    chk("beq_state", 32'(state), 8);
    chk("beq_pwc", 32'(pc_write_cond), 1);
    chk("beq_op", 32'(alu_op), 6);
    chk("beq_psrc", 32'(pc_source), 1);
    tick();
    fetch(6'h02, 6'h00);
    tick();
    chk("j_state", 32'(state), 11);
    chk("j_pcw", 32'(pc_write), 1);
    chk("j_psrc", 32'(pc_source), 2);
    tick();
    chk("bj_cnt", instr_count, 2);

    fetch(6'h3F, 6'h00);
    tick();
    chk("ill_state", 32'(state), 12);
    chk("ill_halted", 32'(halted), 1);
    mem_ready = 1'b1;
    #1;
    chk("ill_pcw", 32'(pc_write), 0);
    chk("ill_mr", 32'(mem_read), 0);
    repeat (20) begin
      tick();
      chk("ill_hold", 32'(state), 12);
    end
    chk("ill_cnt", instr_count, 2);

    do_clear();
    chk("reclr_halted", 32'(halted), 0);
    fetch(6'h00, 6'h01);
    tick();
    chk("badfn_ex", 32'(state), 6);
    tick();
    chk("badfn_state", 32'(state), 12);
    chk("badfn_halted", 32'(halted), 1);
    repeat (5) tick();
    chk("badfn_hold", 32'(state), 12);
    chk("badfn_cnt", instr_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer that replaces the single-cycle decoder so one shared memory and one ALU serve fetch, address calc and PC update over several cycles.
- Moore FSM keyed on the opcode/funct held in the instruction register. Drives all datapath enables and mux selects.
- Supports a memory ready handshake, a retired-instruction counter and a sticky halt on an illegal opcode.

Parameters:
- COUNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- mem_ready  in  1  shared memory completes access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address: 0=PC, 1=ALU out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- reg_dst  out  1  write index: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write data: 0=ALU out, 1=memory data register
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  0=reg B, 1=constant 4, 2=extended imm, 3=extended imm<<2
- imm_ext  out  1  0=sign extend, 1=zero extend
- alu_op  out  3  ALU function: 000 and, 001 or, 010 add, 110 sub, 111 slt
- pc_source  out  2  0=ALU result, 1=ALU out register, 2=jump target
- state  out  4  current state encoding (debug)
- halted  out  1  sticky illegal-opcode flag
- instr_count  out  COUNT_W  retired instructions

Behaviour:
- States (encoding):
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, IMM_EXEC=9, IMM_WB=10, JUMP=11, HALT=12
- clear high (async): state=FETCH, halted=0, instr_count=0, every output 0, including all enables. Outputs take normal values from the first rising edge after clear falls.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=010, pc_source=0.
  - ir_write and pc_write are 1 only in the cycle mem_ready=1; that cycle goes to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=010 (branch target precompute).
  - Next state by opcode: 0x23/0x2B→MEM_ADDR, 0x00→R_EXEC, 0x04→BRANCH, 0x08/0x0D→IMM_EXEC, 0x02→JUMP, any other→HALT.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, imm_ext=0, alu_op=010. Next: 0x23→MEM_READ, 0x2B→MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB when mem_ready=1, else hold.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold while mem_ready=0; when mem_ready=1, retire and go to FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retire, go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0. funct decode: 0x20→010, 0x22→110, 0x24→000, 0x25→001, 0x2A→111. Any other funct→HALT.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=110, pc_write_cond=1, pc_source=1. Retire, go to FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=2. addi: imm_ext=0, alu_op=010. ori: imm_ext=1, alu_op=001.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, with imm_ext/alu_op held as in IMM_EXEC. Retire, go to FETCH.
- JUMP: pc_write=1, pc_source=2. Retire, go to FETCH.
- HALT: halted=1, all enables 0, stays until clear.
- Retire: instr_count increments by 1 on the clock edge leaving a retiring state. It wraps modulo 2^COUNT_W. It does not increment on entering HALT.
- Default value of every unlisted output is 0 in each state.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- opcode/funct are sampled only in DECODE/R_EXEC. Changes elsewhere have no effect.

Test Plan:
- Apply clear mid-MEM_READ with mem_ready=0 → state=0, all enables 0, instr_count=0 in the same cycle, before the next clock edge.
- Run add (opcode 0, funct 0x20) with mem_ready=1 → states 0,1,6,7; alu_op=010 in R_EXEC; reg_dst=1 and reg_write=1 in R_WB; instr_count=1 after 4 cycles.
- Run lw (0x23), holding mem_ready=0 for 3 cycles in FETCH and 2 in MEM_READ → ir_write pulses once; total 10 cycles; mem_to_reg=1 in MEM_WB.
- Run ori (0x0D) → imm_ext=1 and alu_op=001 in both IMM_EXEC and IMM_WB. Run addi (0x08) → imm_ext=0, alu_op=010.
- Run beq (0x04) then j (0x02) → pc_write_cond=1 with alu_op=110 in BRANCH; pc_write=1 with pc_source=2 in JUMP; instr_count=2.
- Issue opcode 0x3F, then R-type funct 0x01 after a fresh clear → HALT, halted=1; state stays 12 for 20 cycles; instr_count unchanged.
